// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, FSM states, command layout.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_GT   = 3'b101;
    localparam logic [2:0] OP_SHLA = 3'b110;
    localparam logic [2:0] OP_SHLB = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } fsm_state_t;

    // Commands are packed as {opcode, rd, rs1, rs2}; this gives the packed width.
    function automatic int cmd_width(input int aw);
        return 3 + 3 * aw;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: pointer-based, one extra pointer bit separates full from empty.
module alu_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr_reg;
    logic [PW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    // A push while full is only legal when a pop frees the slot in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign dout  = mem[rd_ptr_reg[PW-1:0]];

    // Pointer update; both may advance in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[PW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer around the 8-bit ALU: command FIFO, register file, FSM, sticky carry.
module alu_issue_seq #(
    parameter int DATA_W     = 8,
    parameter int NREG       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_opcode,
    input  logic [$clog2(NREG)-1:0] cmd_rd,
    input  logic [$clog2(NREG)-1:0] cmd_rs1,
    input  logic [$clog2(NREG)-1:0] cmd_rs2,
    input  logic                    ld_en,
    input  logic [$clog2(NREG)-1:0] ld_addr,
    input  logic [DATA_W-1:0]       ld_data,
    input  logic                    flag_clr,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [2:0]              alu_opcode,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic                    alu_cout,
    input  logic                    alu_z,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_W-1:0]       res_data,
    output logic                    res_cout,
    output logic                    res_z,
    output logic                    c_flag,
    output logic                    busy
);
    import alu_pkg::*;

    localparam int AW    = $clog2(NREG);
    localparam int CMD_W = cmd_width(AW);

    fsm_state_t        state_reg;
    fsm_state_t        state_next;
    logic [CMD_W-1:0]  fifo_din;
    logic [CMD_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [2:0]        head_op;
    logic [AW-1:0]     head_rd;
    logic [AW-1:0]     head_rs1;
    logic [AW-1:0]     head_rs2;
    logic [2:0]        op_reg;
    logic [AW-1:0]     rd_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] res_data_reg;
    logic              res_cout_reg;
    logic              res_z_reg;
    logic              c_flag_reg;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic              wb_en;

    assign fifo_din  = {cmd_opcode, cmd_rd, cmd_rs1, cmd_rs2};
    assign {head_op, head_rd, head_rs1, head_rs2} = fifo_dout;
    assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full || fifo_pop;
    assign fifo_push = cmd_valid && cmd_ready;
    assign wb_en     = (state_reg == ISSUE);

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rf
            logic [DATA_W-1:0] entry_reg;
            // Register entry: ALU writeback beats a host load to the same entry.
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (wb_en && (rd_reg == AW'(gi))) begin
                    entry_reg <= alu_out;
                end else if (ld_en && (ld_addr == AW'(gi))) begin
                    entry_reg <= ld_data;
                end
            end
            assign rf_q[gi] = entry_reg;
        end
    endgenerate

    // Operand read; a host load landing on the pop edge is forwarded so it is not missed.
    always_comb begin
        rs1_val = rf_q[head_rs1];
        rs2_val = rf_q[head_rs2];
        if (ld_en && (ld_addr == head_rs1)) rs1_val = ld_data;
        if (ld_en && (ld_addr == head_rs2)) rs2_val = ld_data;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next state: pop -> issue one cycle -> hold result until accepted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!fifo_empty) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch at pop, result capture and sticky carry at the issue edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg       <= '0;
            rd_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            res_data_reg <= '0;
            res_cout_reg <= 1'b0;
            res_z_reg    <= 1'b0;
            c_flag_reg   <= 1'b0;
        end else begin
            if (fifo_pop) begin
                op_reg <= head_op;
                rd_reg <= head_rd;
                a_reg  <= rs1_val;
                b_reg  <= rs2_val;
            end
            if (state_reg == ISSUE) begin
                res_data_reg <= alu_out;
                res_cout_reg <= alu_cout;
                res_z_reg    <= alu_z;
                if (alu_cout)      c_flag_reg <= 1'b1;
                else if (flag_clr) c_flag_reg <= 1'b0;
            end
        end
    end

    assign alu_a      = (state_reg == ISSUE) ? a_reg  : '0;
    assign alu_b      = (state_reg == ISSUE) ? b_reg  : '0;
    assign alu_opcode = (state_reg == ISSUE) ? op_reg : 3'b000;
    assign res_valid  = (state_reg == RESP);
    assign res_data   = res_data_reg;
    assign res_cout   = res_cout_reg;
    assign res_z      = res_z_reg;
    assign c_flag     = c_flag_reg;
    assign busy       = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU, vector table, directed corners, random vs model.
module tb_alu_issue_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_opcode;
    logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic       flag_clr;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_out;
    logic       alu_cout, alu_z;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_cout, res_z, c_flag, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_seq #(.DATA_W(8), .NREG(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .flag_clr(flag_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_z(alu_z),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_z(res_z), .c_flag(c_flag), .busy(busy)
    );

    // ALU behaviour as plain arithmetic: returns {cout, out}.
    function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        r = 9'd0;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a - b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_GT:   r = (a > b) ? 9'd1 : 9'd0;
            OP_SHLA: r = {1'b0, a[6:0], 1'b0};
            default: r = {1'b0, b[6:0], 1'b0};
        endcase
        return r;
    endfunction

    // Stand-in for the ALU that normally sits one level up.
    always_comb begin
        {alu_cout, alu_out} = ref_alu(alu_opcode, alu_a, alu_b);
        alu_z = (alu_out == 8'd0);
    end

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_cout;
        logic       exp_z;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       cout;
        logic       z;
        logic       cflag;
    } exp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic ld_reg(input logic [1:0] addr, input logic [7:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!res_valid && n < budget) begin
            tick();
            n++;
        end
        chk(name, res_valid, 1);
    endtask

    // One command from an idle sequencer, with exact latency and ALU-port checks.
    task automatic do_cmd(input string name, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] ea,
                          input logic [7:0] eb, input logic [7:0] ed, input logic ec, input logic ez);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        chk({name, "_ready"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk({name, "_alu_a"}, alu_a, ea);
        chk({name, "_alu_b"}, alu_b, eb);
        chk({name, "_alu_op"}, alu_opcode, op);
        chk({name, "_early_valid"}, res_valid, 0);
        tick();
        chk({name, "_valid"}, res_valid, 1);
        chk({name, "_data"}, res_data, ed);
        chk({name, "_cout"}, res_cout, ec);
        chk({name, "_z"}, res_z, ez);
        chk({name, "_alu_a_idle"}, alu_a, 0);
        $display("txn %s op=%0d data=%02h cout=%0b z=%0b", name, op, res_data, res_cout, res_z);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({name, "_drop"}, res_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vt [10];
        logic [2:0] fill_op  [6];
        logic [7:0] fill_exp [6];
        logic [7:0] m_rf [4];
        logic       m_cflag;
        logic [8:0] r;
        exp_t       e;
        exp_t       exp_q [$];

        vt[0] = {OP_ADD,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
        vt[1] = {OP_XOR,  8'h55, 8'h55, 8'h00, 1'b0, 1'b1};
        vt[2] = {OP_SUB,  8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vt[3] = {OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vt[4] = {OP_OR,   8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0};
        vt[5] = {OP_GT,   8'h80, 8'h7F, 8'h01, 1'b0, 1'b0};
        vt[6] = {OP_GT,   8'h10, 8'h10, 8'h00, 1'b0, 1'b1};
        vt[7] = {OP_SHLA, 8'h81, 8'h22, 8'h02, 1'b0, 1'b0};
        vt[8] = {OP_SHLB, 8'h11, 8'hC3, 8'h86, 1'b0, 1'b0};
        vt[9] = {OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};

        fill_op[0] = OP_ADD;  fill_exp[0] = 8'h08;
        fill_op[1] = OP_SUB;  fill_exp[1] = 8'h02;
        fill_op[2] = OP_SHLA; fill_exp[2] = 8'h0A;
        fill_op[3] = OP_SHLB; fill_exp[3] = 8'h06;
        fill_op[4] = OP_GT;   fill_exp[4] = 8'h01;
        fill_op[5] = OP_OR;   fill_exp[5] = 8'h07;

        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0;
        ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'd0; flag_clr = 1'b0; res_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_c_flag", c_flag, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_res_data", res_data, 0);

        // Vector table: flag_clr held high, so c_flag after each command equals its carry.
        for (int i = 0; i < 10; i++) begin
            ld_reg(2'd0, vt[i].a);
            ld_reg(2'd1, vt[i].b);
            flag_clr = 1'b1;
            do_cmd($sformatf("vec%0d", i), vt[i].op, 2'd2, 2'd0, 2'd1, vt[i].a, vt[i].b,
                   vt[i].exp_data, vt[i].exp_cout, vt[i].exp_z);
            flag_clr = 1'b0;
            chk($sformatf("vec%0d_c_flag", i), c_flag, vt[i].exp_cout);
            do_cmd($sformatf("vec%0d_rd2", i), OP_OR, 2'd3, 2'd2, 2'd2, vt[i].exp_data,
                   vt[i].exp_data, vt[i].exp_data, 1'b0, vt[i].exp_data == 8'd0);
        end

        // Writeback visible to the next command
        ld_reg(2'd0, 8'h55);
        ld_reg(2'd1, 8'h55);
        do_cmd("xor_r3", OP_XOR, 2'd3, 2'd0, 2'd1, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1);
        do_cmd("sub_r3r3", OP_SUB, 2'd0, 2'd3, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        // FIFO fill while a result is held in RESP
        ld_reg(2'd0, 8'h05);
        ld_reg(2'd1, 8'h03);
        cmd_valid = 1'b1; cmd_opcode = fill_op[0]; cmd_rd = 2'd3; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("fill_c0_valid", res_valid, 1);
        for (int k = 1; k < 6; k++) begin
            cmd_valid = 1'b1; cmd_opcode = fill_op[k];
            chk($sformatf("fill_ready%0d", k), cmd_ready, (k <= 4) ? 1 : 0);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            chk("hold_data", res_data, 8'h08);
            chk("hold_cout", res_cout, 0);
            chk("hold_z", res_z, 0);
            chk("hold_valid", res_valid, 1);
            chk("hold_full", cmd_ready, 0);
            tick();
        end
        $display("txn fill0 data=%02h", res_data);
        res_ready = 1'b1;
        tick();
        chk("full_pop_valid", res_valid, 0);
        chk("full_pop_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k < 6; k++) begin
            wait_valid($sformatf("fill_wait%0d", k), 20);
            chk($sformatf("fill_data%0d", k), res_data, fill_exp[k]);
            $display("txn fill%0d data=%02h", k, res_data);
            tick();
        end
        res_ready = 1'b0;
        chk("fill_idle", busy, 0);

        // Load and writeback on the same cycle: same address, then different addresses.
        ld_reg(2'd0, 8'hF0);
        ld_reg(2'd1, 8'h20);
        cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hAA; flag_clr = 1'b1;
        tick();
        ld_en = 1'b0; flag_clr = 1'b0;
        chk("conf_data", res_data, 8'h10);
        chk("conf_c_flag", c_flag, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        do_cmd("conf_r2", OP_OR, 2'd3, 2'd2, 2'd2, 8'h10, 8'h10, 8'h10, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h44;
        tick();
        ld_en = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        do_cmd("diff_r1", OP_OR, 2'd3, 2'd1, 2'd1, 8'h44, 8'h44, 8'h44, 1'b0, 1'b0);
        do_cmd("diff_r2", OP_OR, 2'd3, 2'd2, 2'd2, 8'h10, 8'h10, 8'h10, 1'b0, 1'b0);

        // Reset during ISSUE with a second command still queued
        cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
        tick();
        tick();
        cmd_valid = 1'b0;
        chk("pre_rst_issue", alu_opcode, OP_ADD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_c_flag", c_flag, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_res_data", res_data, 0);
        tick();
        tick();
        chk("mid_rst_no_result", res_valid, 0);
        chk("mid_rst_still_idle", busy, 0);
        for (int i = 0; i < 4; i++) begin
            do_cmd($sformatf("rst_rf%0d", i), OP_OR, 2'(i), 2'(i), 2'(i), 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        end

        // Random traffic against a transaction-level model (regfile now all zero, c_flag 0).
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_cflag = 1'b0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_opcode = 3'($urandom_range(0, 7));
            cmd_rd     = 2'($urandom_range(0, 3));
            cmd_rs1    = 2'($urandom_range(0, 3));
            cmd_rs2    = 2'($urandom_range(0, 3));
            res_ready  = ($urandom_range(0, 4) != 0);
            ld_en      = !busy && ($urandom_range(0, 2) == 0);
            ld_addr    = 2'($urandom_range(0, 3));
            ld_data    = 8'($urandom_range(0, 255));
            if (ld_en) m_rf[ld_addr] = ld_data;
            if (cmd_valid && cmd_ready) begin
                r = ref_alu(cmd_opcode, m_rf[cmd_rs1], m_rf[cmd_rs2]);
                m_rf[cmd_rd] = r[7:0];
                if (r[8]) m_cflag = 1'b1;
                exp_q.push_back({r[7:0], r[8], r[7:0] == 8'd0, m_cflag});
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious", res_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_data", res_data, e.data);
                    chk("rnd_cout", res_cout, e.cout);
                    chk("rnd_z", res_z, e.z);
                    chk("rnd_c_flag", c_flag, e.cflag);
                    $display("txn rnd cyc=%0d data=%02h cout=%0b z=%0b", cyc, res_data, res_cout, res_z);
                end
            end
            tick();
        end
        cmd_valid = 1'b0; ld_en = 1'b0; res_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) begin
            if (res_valid) begin
                e = exp_q.pop_front();
                chk("drain_data", res_data, e.data);
                chk("drain_cout", res_cout, e.cout);
                chk("drain_z", res_z, e.z);
                chk("drain_c_flag", c_flag, e.cflag);
                $display("txn drain data=%02h cout=%0b z=%0b", res_data, res_cout, res_z);
            end
            tick();
        end
        chk("drain_empty", exp_q.size(), 0);
        tick();
        chk("drain_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
